// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: exception codes, mem_op field layout and size encodings.
package ex_mem_stage_pkg;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;

  localparam int MEMOP_STORE = 3;
  localparam int MEMOP_LOAD  = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return op[MEMOP_STORE] | op[MEMOP_LOAD];
  endfunction

endpackage

// File: rtl/ex_mem_stage_store_lane_gen.sv
// Byte-strobe / lane-replication generator for data-memory requests.
// MEM_ALIGN_CHECK_EN enables reporting of misaligned half/word accesses.
module ex_mem_stage_store_lane_gen
  import ex_mem_stage_pkg::*;
(
  input  logic        i_store,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  logic [3:0] w_strb;

  always_comb begin
    w_strb       = 4'b1111;
    o_wdata      = i_data;
    o_misaligned = 1'b0;
    case (i_size)
      SIZE_BYTE: begin
        w_strb  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      SIZE_HALF: begin
        w_strb  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_data[15:0]}};
`ifdef MEM_ALIGN_CHECK_EN
        o_misaligned = i_addr_lo[0];
`endif
      end
      default: begin
`ifdef MEM_ALIGN_CHECK_EN
        o_misaligned = |i_addr_lo;
`endif
      end
    endcase
    // Loads never write, so they present an all-zero strobe.
    o_wstrb = i_store ? w_strb : 4'b0000;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: exception resolution, data-memory request issue, WB handoff.
// Alignment exceptions are produced only when MEM_ALIGN_CHECK_EN is defined.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_allowin,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_addr,
  input  logic        ex_overflow,
  input  logic        ex_trap,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest,
  input  logic        ex_wen,
  input  logic        ex_exc,
  input  logic [4:0]  ex_exccode,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [4:0]  mem_dest,
  output logic        mem_wen,
  output logic [3:0]  mem_mem_op,
  output logic        mem_exc,
  output logic [4:0]  mem_exccode,
  output logic [31:0] mem_badvaddr,
  output logic        exc_pending
);

  logic        r_mem_valid, r_req_sent, r_exc_block;
  logic [31:0] r_pc, r_result, r_addr, r_wdata, r_badvaddr;
  logic [4:0]  r_dest, r_exccode;
  logic        r_wen, r_exc;
  logic [3:0]  r_mem_op, r_wstrb;

  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_badvaddr;
  logic        w_misaligned, w_ade, w_exc_any, w_memop, w_ready_go, w_capture;
  logic [4:0]  w_exccode;

  ex_mem_stage_store_lane_gen u_lane_gen (
    .i_store      (ex_mem_op[MEMOP_STORE]),
    .i_size       (ex_mem_op[1:0]),
    .i_addr_lo    (ex_addr[1:0]),
    .i_data       (ex_store_data),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_ade = is_mem_op(ex_mem_op) & w_misaligned;

  // Priority: upstream exception > overflow > trap > address error.
  always_comb begin
    w_exc_any  = 1'b1;
    w_exccode  = 5'd0;
    w_badvaddr = 32'd0;
    if (ex_exc) begin
      w_exccode = ex_exccode;
    end else if (ex_overflow) begin
      w_exccode = EXC_OV;
    end else if (ex_trap) begin
      w_exccode = EXC_TR;
    end else if (w_ade) begin
      w_exccode  = ex_mem_op[MEMOP_STORE] ? EXC_ADES : EXC_ADEL;
      w_badvaddr = ex_addr;
    end else begin
      w_exc_any = 1'b0;
    end
  end

  assign w_memop    = is_mem_op(r_mem_op);
  assign data_req   = r_mem_valid & w_memop & ~r_exc & ~r_exc_block & ~r_req_sent & ~flush;
  assign w_ready_go = ~w_memop | r_exc | r_exc_block | r_req_sent | (data_req & data_addr_ok);
  assign ex_allowin = ~r_mem_valid | (w_ready_go & wb_allowin);
  assign w_capture  = ex_valid & ex_allowin & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
      r_req_sent  <= 1'b0;
      r_exc_block <= 1'b0;
    end else if (flush) begin
      r_mem_valid <= 1'b0;
      r_req_sent  <= 1'b0;
      r_exc_block <= 1'b0;
    end else begin
      if (ex_allowin) r_mem_valid <= ex_valid;
      if (w_capture) begin
        r_req_sent <= 1'b0;
        if (w_exc_any) r_exc_block <= 1'b1;
      end else if (data_req & data_addr_ok) begin
        r_req_sent <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= 32'd0;
      r_result   <= 32'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_badvaddr <= 32'd0;
      r_dest     <= 5'd0;
      r_exccode  <= 5'd0;
      r_wen      <= 1'b0;
      r_exc      <= 1'b0;
      r_mem_op   <= 4'd0;
      r_wstrb    <= 4'd0;
    end else if (w_capture) begin
      r_pc       <= ex_pc;
      r_result   <= ex_result;
      r_addr     <= ex_addr;
      r_wdata    <= w_wdata;
      r_badvaddr <= w_badvaddr;
      r_dest     <= ex_dest;
      r_exccode  <= w_exccode;
      r_wen      <= ex_wen & ~w_exc_any;
      r_exc      <= w_exc_any;
      r_mem_op   <= ex_mem_op;
      r_wstrb    <= w_wstrb;
    end
  end

  assign data_wr         = r_mem_op[MEMOP_STORE];
  assign data_wstrb      = r_wstrb;
  assign data_addr       = r_addr;
  assign data_wdata      = r_wdata;
  assign mem_to_wb_valid = r_mem_valid & w_ready_go;
  assign mem_pc          = r_pc;
  assign mem_result      = r_result;
  assign mem_dest        = r_dest;
  // Instructions behind a latched exception must not write the register file.
  assign mem_wen         = r_wen & ~r_exc_block;
  assign mem_mem_op      = r_mem_op;
  assign mem_exc         = r_exc;
  assign mem_exccode     = r_exccode;
  assign mem_badvaddr    = r_badvaddr;
  assign exc_pending     = r_exc_block;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected requests/WB handoffs queued at issue, checked by a monitor.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, ex_valid, ex_allowin;
  logic [31:0] ex_pc, ex_result, ex_addr, ex_store_data;
  logic        ex_overflow, ex_trap, ex_wen, ex_exc;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_dest, ex_exccode;
  logic        data_req, data_wr, data_addr_ok, wb_allowin, mem_to_wb_valid;
  logic [3:0]  data_wstrb, mem_mem_op;
  logic [31:0] data_addr, data_wdata, mem_pc, mem_result, mem_badvaddr;
  logic [4:0]  mem_dest, mem_exccode;
  logic        mem_wen, mem_exc, exc_pending;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .ex_valid(ex_valid), .ex_allowin(ex_allowin),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_addr(ex_addr), .ex_overflow(ex_overflow),
    .ex_trap(ex_trap), .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_wen(ex_wen), .ex_exc(ex_exc), .ex_exccode(ex_exccode), .data_req(data_req),
    .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_pc(mem_pc), .mem_result(mem_result), .mem_dest(mem_dest), .mem_wen(mem_wen),
    .mem_mem_op(mem_mem_op), .mem_exc(mem_exc), .mem_exccode(mem_exccode),
    .mem_badvaddr(mem_badvaddr), .exc_pending(exc_pending)
  );

  typedef struct {
    logic [31:0] pc, result, badv;
    logic [4:0]  dest, code;
    logic        wen, exc;
  } wb_t;
  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        wr;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  wb_t  mon_wb;
  req_t mon_req;
  int   n_vec = 0, n_fail = 0, n_req_hs = 0;

  localparam logic [3:0] OP_ALU = 4'b0000, OP_LW = 4'b0110;
  localparam logic [3:0] OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endfunction

  function automatic void exp_wb(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                                 input logic wen, input logic exc, input logic [4:0] code,
                                 input logic [31:0] badv);
    wb_t e;
    e.pc = pc; e.result = res; e.dest = dest; e.wen = wen; e.exc = exc; e.code = code; e.badv = badv;
    wb_q.push_back(e);
  endfunction

  function automatic void exp_req(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                                  input logic [31:0] wdata);
    req_t e;
    e.addr = addr; e.wr = wr; e.strb = strb; e.wdata = wdata;
    req_q.push_back(e);
  endfunction

  // Monitor: a handshake seen at the negedge is the one that completes at the next posedge.
  always @(negedge clk) begin
    if (resetn) begin
      if (data_req && data_addr_ok) begin
        n_req_hs++;
        if (req_q.size() == 0) chk("req_q_depth", 32'(req_q.size()), 32'd1);
        else begin
          mon_req = req_q.pop_front();
          chk("req_addr", data_addr, mon_req.addr);
          chk1("req_wr", data_wr, mon_req.wr);
          chk("req_wstrb", {28'd0, data_wstrb}, {28'd0, mon_req.strb});
          if (mon_req.wr) chk("req_wdata", data_wdata, mon_req.wdata);
        end
      end
      if (mem_to_wb_valid && wb_allowin) begin
        if (wb_q.size() == 0) chk("wb_q_depth", 32'(wb_q.size()), 32'd1);
        else begin
          mon_wb = wb_q.pop_front();
          chk("wb_pc", mem_pc, mon_wb.pc);
          chk("wb_result", mem_result, mon_wb.result);
          chk("wb_dest", {27'd0, mem_dest}, {27'd0, mon_wb.dest});
          chk1("wb_wen", mem_wen, mon_wb.wen);
          chk1("wb_exc", mem_exc, mon_wb.exc);
          chk("wb_exccode", {27'd0, mem_exccode}, {27'd0, mon_wb.code});
          chk("wb_badvaddr", mem_badvaddr, mon_wb.badv);
        end
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] res, input logic [31:0] sd, input logic [4:0] dest,
                      input logic wen, input logic ov, input logic tr, input logic exc,
                      input logic [4:0] code);
    int n = 0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_pc = pc; ex_mem_op = op; ex_addr = addr; ex_result = res;
    ex_store_data = sd; ex_dest = dest; ex_wen = wen; ex_overflow = ov; ex_trap = tr;
    ex_exc = exc; ex_exccode = code;
    @(negedge clk);
    while (!ex_allowin && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_in_time", n < 40, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_overflow = 1'b0; ex_trap = 1'b0; ex_exc = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    resetn = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_result = '0; ex_addr = '0;
    ex_overflow = 1'b0; ex_trap = 1'b0; ex_mem_op = '0; ex_store_data = '0; ex_dest = '0;
    ex_wen = 1'b0; ex_exc = 1'b0; ex_exccode = '0; data_addr_ok = 1'b1; wb_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk1("rst_wb_valid", mem_to_wb_valid, 1'b0);
    chk1("rst_data_req", data_req, 1'b0);
    chk1("rst_exc_pending", exc_pending, 1'b0);
    chk1("rst_allowin", ex_allowin, 1'b1);
    chk("rst_mem_pc", mem_pc, 32'd0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);

    // sw accepted on the second request cycle: one request, one stall cycle.
    data_addr_ok = 1'b0;
    hs0 = n_req_hs;
    exp_req(32'h1000_0004, 1'b1, 4'b1111, 32'hA5A5_1234);
    exp_wb(32'h100, 32'h1000_0004, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h100, OP_SW, 32'h1000_0004, 32'h1000_0004, 32'hA5A5_1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk1("sw_stall_valid", mem_to_wb_valid, 1'b0);
    chk1("sw_req_pending", data_req, 1'b1);
    chk1("sw_stall_allowin", ex_allowin, 1'b0);
    @(posedge clk); #1 data_addr_ok = 1'b1;
    @(negedge clk);
    chk1("sw_go_valid", mem_to_wb_valid, 1'b1);
    @(negedge clk);
    chk("sw_one_req", 32'(n_req_hs - hs0), 32'd1);

    // Lane generation for sub-word stores, a load and a plain ALU op.
    exp_req(32'h2000_0003, 1'b1, 4'b1000, 32'h7777_7777);
    exp_wb(32'h104, 32'h2000_0003, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h104, OP_SB, 32'h2000_0003, 32'h2000_0003, 32'h0000_0077, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    exp_req(32'h2000_0002, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    exp_wb(32'h108, 32'h2000_0002, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h108, OP_SH, 32'h2000_0002, 32'h2000_0002, 32'h1234_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    exp_req(32'h3000_0008, 1'b0, 4'b0000, 32'd0);
    exp_wb(32'h10C, 32'h3000_0008, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0);
    send(32'h10C, OP_LW, 32'h3000_0008, 32'h3000_0008, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    exp_wb(32'h110, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    send(32'h110, OP_ALU, 32'h0, 32'hDEAD_BEEF, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

    // Overflow latches a block: younger sw gets no request, younger ALU op loses wen.
    exp_wb(32'h200, 32'h8000_0000, 5'd3, 1'b0, 1'b1, 5'h0C, 32'd0);
    send(32'h200, OP_ALU, 32'h0, 32'h8000_0000, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk1("ov_pending", exc_pending, 1'b1);
    exp_wb(32'h204, 32'h1000_0010, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h204, OP_SW, 32'h1000_0010, 32'h1000_0010, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk1("blk_data_req", data_req, 1'b0);
    chk1("blk_pending", exc_pending, 1'b1);
    exp_wb(32'h208, 32'h0000_0055, 5'd9, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h208, OP_ALU, 32'h0, 32'h0000_0055, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    pulse_flush();
    @(negedge clk);
    chk1("flush_clears_pending", exc_pending, 1'b0);
    exp_req(32'h1000_0020, 1'b1, 4'b1111, 32'h0BAD_F00D);
    exp_wb(32'h20C, 32'h1000_0020, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    send(32'h20C, OP_SW, 32'h1000_0020, 32'h1000_0020, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Exception priority.
    exp_wb(32'h300, 32'h1000_0030, 5'd0, 1'b0, 1'b1, 5'h0C, 32'd0);
    send(32'h300, OP_SW, 32'h1000_0030, 32'h1000_0030, 32'h2222_2222, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    pulse_flush();
    exp_wb(32'h304, 32'h0000_0001, 5'd2, 1'b0, 1'b1, 5'h0D, 32'd0);
    send(32'h304, OP_ALU, 32'h0, 32'h0000_0001, 32'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    pulse_flush();
    exp_wb(32'h308, 32'h0000_0002, 5'd2, 1'b0, 1'b1, 5'h08, 32'd0);
    send(32'h308, OP_ALU, 32'h0, 32'h0000_0002, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'h08);
    pulse_flush();

    // Misaligned accesses.
`ifdef MEM_ALIGN_CHECK_EN
    exp_wb(32'h400, 32'h4000_0002, 5'd4, 1'b0, 1'b1, 5'h04, 32'h4000_0002);
`else
    exp_req(32'h4000_0002, 1'b0, 4'b0000, 32'd0);
    exp_wb(32'h400, 32'h4000_0002, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0);
`endif
    send(32'h400, OP_LW, 32'h4000_0002, 32'h4000_0002, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    pulse_flush();
`ifdef MEM_ALIGN_CHECK_EN
    exp_wb(32'h404, 32'h4000_0001, 5'd0, 1'b0, 1'b1, 5'h05, 32'h4000_0001);
`else
    exp_req(32'h4000_0001, 1'b1, 4'b0011, 32'hCAFE_CAFE);
    exp_wb(32'h404, 32'h4000_0001, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
`endif
    send(32'h404, OP_SH, 32'h4000_0001, 32'h4000_0001, 32'h0000_CAFE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    pulse_flush();

    // Flush with a request pending and a younger instruction waiting in EX.
    data_addr_ok = 1'b0;
    send(32'h500, OP_LW, 32'h5000_0000, 32'h5000_0000, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    ex_valid = 1'b1; ex_pc = 32'h504; ex_mem_op = OP_SW; ex_addr = 32'h5000_0004; flush = 1'b1;
    @(negedge clk);
    chk1("flush_no_req", data_req, 1'b0);
    chk1("flush_no_wb", mem_to_wb_valid, 1'b0);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    chk1("post_flush_wb", mem_to_wb_valid, 1'b0);
    chk1("post_flush_req", data_req, 1'b0);
    @(posedge clk); #1 ex_valid = 1'b1; ex_pc = 32'h508; flush = 1'b1;
    @(negedge clk);
    chk1("flush_cap_allowin", ex_allowin, 1'b1);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    chk1("flush_cap_wb", mem_to_wb_valid, 1'b0);
    chk1("flush_cap_req", data_req, 1'b0);
    data_addr_ok = 1'b1;

    // WB back-pressure after the request has been accepted.
    wb_allowin = 1'b0;
    hs0 = n_req_hs;
    exp_req(32'h6000_0004, 1'b0, 4'b0000, 32'd0);
    exp_wb(32'h600, 32'h1111_2222, 5'd8, 1'b1, 1'b0, 5'd0, 32'd0);
    send(32'h600, OP_LW, 32'h6000_0004, 32'h1111_2222, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk1("stall_req_first", data_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall_no_reissue", data_req, 1'b0);
      chk1("stall_allowin", ex_allowin, 1'b0);
      chk1("stall_wb_valid", mem_to_wb_valid, 1'b1);
      chk("stall_pc", mem_pc, 32'h600);
      chk("stall_result", mem_result, 32'h1111_2222);
    end
    @(posedge clk); #1 wb_allowin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_one_req", 32'(n_req_hs - hs0), 32'd1);

    repeat (3) @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
